// File: rtl/usb_buffer_arbiter.sv
// Arbitrates the shared USB data buffer between the RX engine, the TX engine and the AHB host port.
// The owner is locked for a whole packet or host session, and its strobes are muxed onto the buffer port.
module usb_buffer_arbiter #(
  parameter int DEPTH   = 64,
  parameter int OCC_W   = 7,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_req,
  input  logic             rx_store,
  input  logic [7:0]       rx_wdata,
  input  logic             tx_req,
  input  logic             tx_get,
  input  logic             host_req,
  input  logic             host_store,
  input  logic [7:0]       host_wdata,
  input  logic             host_get,
  input  logic             host_clear,
  input  logic [OCC_W-1:0] buffer_occupancy,
  output logic             gnt_rx,
  output logic             gnt_tx,
  output logic             gnt_host,
  output logic             buf_store,
  output logic [7:0]       buf_wdata,
  output logic             buf_get,
  output logic             buf_flush,
  output logic             access_err,
  output logic             host_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RX,
    ST_TX,
    ST_HOST
  } state_e;

  localparam logic [OCC_W-1:0] OCC_FULL    = OCC_W'(DEPTH);
  localparam logic [7:0]       TIMEOUT_CNT = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic       access_err_q, access_err_d;
  logic       host_timeout_q, host_timeout_d;

  logic       store_req;
  logic       get_req;
  logic       clear_req;
  logic [7:0] wdata_sel;
  logic       buf_full;
  logic       buf_empty;
  logic       host_activity;
  logic [7:0] idle_cnt_inc;

  assign buf_full      = (buffer_occupancy >= OCC_FULL);
  assign buf_empty     = (buffer_occupancy == '0);
  assign host_activity = host_store | host_get | host_clear;
  assign idle_cnt_inc  = idle_cnt_q + 8'd1;

  assign gnt_rx       = (state_q == ST_RX);
  assign gnt_tx       = (state_q == ST_TX);
  assign gnt_host     = (state_q == ST_HOST);
  assign access_err   = access_err_q;
  assign host_timeout = host_timeout_q;

  // Only the current owner's strobes reach the buffer; everything else is dropped silently.
  always_comb begin
    store_req = 1'b0;
    get_req   = 1'b0;
    clear_req = 1'b0;
    wdata_sel = 8'h00;
    case (state_q)
      ST_RX: begin
        store_req = rx_store;
        wdata_sel = rx_wdata;
      end
      ST_TX: begin
        get_req = tx_get;
      end
      ST_HOST: begin
        store_req = host_store;
        get_req   = host_get;
        clear_req = host_clear;
        wdata_sel = host_wdata;
      end
      default: begin
        store_req = 1'b0;
      end
    endcase
  end

  // A clear overrides any same-cycle store/get; a store beats a colliding get.
  always_comb begin
    buf_store    = 1'b0;
    buf_get      = 1'b0;
    buf_wdata    = 8'h00;
    buf_flush    = (state_q == ST_FLUSH);
    access_err_d = 1'b0;
    if (clear_req) begin
      buf_flush = 1'b1;
    end else begin
      buf_store    = store_req && !buf_full;
      buf_get      = get_req && !store_req && !buf_empty;
      buf_wdata    = buf_store ? wdata_sel : 8'h00;
      access_err_d = (store_req && buf_full) ||
                     (get_req && buf_empty) ||
                     (store_req && get_req);
    end
  end

  always_comb begin
    state_d        = state_q;
    idle_cnt_d     = 8'h00;
    host_timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_req) begin
          state_d = ST_FLUSH;
        end else if (tx_req) begin
          state_d = ST_TX;
        end else if (host_req) begin
          state_d = ST_HOST;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RX;
      end
      ST_RX: begin
        if (!rx_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_TX: begin
        if (!tx_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOST: begin
        // A silent host loses the lock once the idle counter reaches the limit.
        if (!host_req) begin
          state_d = ST_IDLE;
        end else if (!host_activity) begin
          idle_cnt_d = idle_cnt_inc;
          if (idle_cnt_inc == TIMEOUT_CNT) begin
            state_d        = ST_IDLE;
            host_timeout_d = 1'b1;
            idle_cnt_d     = 8'h00;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      idle_cnt_q     <= 8'h00;
      access_err_q   <= 1'b0;
      host_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idle_cnt_q     <= idle_cnt_d;
      access_err_q   <= access_err_d;
      host_timeout_q <= host_timeout_d;
    end
  end

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// Self-checking bench for usb_buffer_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against an ownership-level reference model.
module tb_usb_buffer_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_req, rx_store, tx_req, tx_get;
  logic       host_req, host_store, host_get, host_clear;
  logic [7:0] rx_wdata, host_wdata;
  logic [6:0] buffer_occupancy;
  logic       gnt_rx, gnt_tx, gnt_host;
  logic       buf_store, buf_get, buf_flush, access_err, host_timeout;
  logic [7:0] buf_wdata;

  always #5 clk = ~clk;

  usb_buffer_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .rx_req           (rx_req),
    .rx_store         (rx_store),
    .rx_wdata         (rx_wdata),
    .tx_req           (tx_req),
    .tx_get           (tx_get),
    .host_req         (host_req),
    .host_store       (host_store),
    .host_wdata       (host_wdata),
    .host_get         (host_get),
    .host_clear       (host_clear),
    .buffer_occupancy (buffer_occupancy),
    .gnt_rx           (gnt_rx),
    .gnt_tx           (gnt_tx),
    .gnt_host         (gnt_host),
    .buf_store        (buf_store),
    .buf_wdata        (buf_wdata),
    .buf_get          (buf_get),
    .buf_flush        (buf_flush),
    .access_err       (access_err),
    .host_timeout     (host_timeout)
  );

  localparam logic [15:0] M_GNT   = 16'hE000;
  localparam logic [15:0] M_STORE = 16'h1000;
  localparam logic [15:0] M_GET   = 16'h0008;
  localparam logic [15:0] M_FLUSH = 16'h0004;
  localparam logic [15:0] M_ERR   = 16'h0002;
  localparam logic [15:0] M_TO    = 16'h0001;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: who owns the buffer, how long the host has been silent, and pending pulses.
  string m_owner    = "none";
  int    m_idle     = 0;
  logic  m_err_prev = 1'b0;
  logic  m_to_prev  = 1'b0;
  logic [15:0] last_obs;

  task automatic model_comb(output logic [15:0] v, output logic err_now);
    logic st, gt, cl, fl, sp, gp, full, empty;
    logic [2:0] g;
    logic [7:0] wd, wout;
    st = 1'b0; gt = 1'b0; cl = 1'b0; fl = 1'b0; sp = 1'b0; gp = 1'b0;
    g = 3'b000; wd = 8'h00; wout = 8'h00; err_now = 1'b0;
    full  = (buffer_occupancy == 7'd64);
    empty = (buffer_occupancy == 7'd0);
    if (m_owner == "flush") fl = 1'b1;
    if (m_owner == "rx")   begin g = 3'b100; st = rx_store; wd = rx_wdata; end
    if (m_owner == "tx")   begin g = 3'b010; gt = tx_get; end
    if (m_owner == "host") begin
      g = 3'b001; st = host_store; gt = host_get; cl = host_clear; wd = host_wdata;
    end
    if (cl) begin
      fl = 1'b1;
    end else begin
      sp      = st && !full;
      gp      = gt && !st && !empty;
      wout    = sp ? wd : 8'h00;
      err_now = (st && full) || (gt && empty) || (st && gt);
    end
    v = {g, sp, wout, gp, fl, m_err_prev, m_to_prev};
  endtask

  task automatic model_step();
    logic [15:0] v;
    logic        err_now;
    model_comb(v, err_now);
    if (rst) begin
      m_owner = "none"; m_idle = 0; m_err_prev = 1'b0; m_to_prev = 1'b0;
      return;
    end
    m_err_prev = err_now;
    m_to_prev  = 1'b0;
    if (m_owner == "none") begin
      m_idle = 0;
      if (rx_req)        m_owner = "flush";
      else if (tx_req)   m_owner = "tx";
      else if (host_req) m_owner = "host";
    end else if (m_owner == "flush") begin
      m_owner = "rx";
    end else if (m_owner == "rx") begin
      if (!rx_req) m_owner = "none";
    end else if (m_owner == "tx") begin
      if (!tx_req) m_owner = "none";
    end else begin
      if (!host_req) begin
        m_owner = "none"; m_idle = 0;
      end else if (host_store || host_get || host_clear) begin
        m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == 255) begin
          m_owner = "none"; m_idle = 0; m_to_prev = 1'b1;
        end
      end
    end
  endtask

  task automatic checkOutput(string tag);
    logic [15:0] exp_v, obs;
    logic        unused_err;
    model_comb(exp_v, unused_err);
    obs = {gnt_rx, gnt_tx, gnt_host, buf_store, buf_wdata, buf_get, buf_flush,
           access_err, host_timeout};
    last_obs = obs;
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic expectField(string tag, logic [15:0] mask, logic [15:0] want);
    checks++;
    assert ((last_obs & mask) === want) else begin
      errors++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, last_obs & mask, want);
    end
  endtask

  // Runs one clock with the currently staged inputs: check mid-cycle, then advance the model.
  task automatic applyStimulus(string tag);
    @(negedge clk);
    checkOutput(tag);
    @(posedge clk);
    #1;
    model_step();
    cyc++;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; rx_req = 1'b0; rx_store = 1'b0; rx_wdata = 8'h00;
    tx_req = 1'b0; tx_get = 1'b0; host_req = 1'b0; host_store = 1'b0;
    host_wdata = 8'h00; host_get = 1'b0; host_clear = 1'b0; buffer_occupancy = 7'd20;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("reset");
    expectField("reset_all_zero", 16'hFFFF, 16'h0000);
    rst = 1'b0;

    // TX and host requested together: TX wins, host follows after one idle cycle.
    tx_req = 1'b1; host_req = 1'b1;
    applyStimulus("s1_idle");   expectField("s1_idle_gnt", M_GNT, 16'h0000);
    applyStimulus("s1_tx");     expectField("s1_gnt_tx", M_GNT, 16'h4000);
    tx_req = 1'b0;
    applyStimulus("s1_txdrop"); expectField("s1_tx_hold", M_GNT, 16'h4000);
    applyStimulus("s1_gap");    expectField("s1_gap_gnt", M_GNT, 16'h0000);
    applyStimulus("s1_host");   expectField("s1_gnt_host", M_GNT, 16'h2000);
    host_req = 1'b0;
    applyStimulus("s1_hdrop");
    applyStimulus("s1_idle2");

    // RX arriving during TX waits, then gets a one-cycle flush before its grant.
    tx_req = 1'b1;
    applyStimulus("s2_idle");
    applyStimulus("s2_tx");
    rx_req = 1'b1;
    applyStimulus("s2_nopre1"); expectField("s2_no_preempt", M_GNT, 16'h4000);
    applyStimulus("s2_nopre2");
    tx_req = 1'b0;
    applyStimulus("s2_txdrop");
    applyStimulus("s2_gap");    expectField("s2_gap", M_GNT | M_FLUSH, 16'h0000);
    applyStimulus("s2_flush");  expectField("s2_flush", M_GNT | M_FLUSH, 16'h0004);
    applyStimulus("s2_rx");     expectField("s2_gnt_rx", M_GNT | M_FLUSH, 16'h8000);

    // RX store into a full buffer is suppressed and flagged a cycle later.
    buffer_occupancy = 7'd64; rx_store = 1'b1; rx_wdata = 8'hAA;
    applyStimulus("s3_full");   expectField("s3_store_blocked", 16'h1FF0, 16'h0000);
    rx_store = 1'b0;
    applyStimulus("s3_err");    expectField("s3_err_pulse", M_ERR, M_ERR);
    applyStimulus("s3_err_end"); expectField("s3_err_once", M_ERR, 16'h0000);
    buffer_occupancy = 7'd10; rx_store = 1'b1;
    applyStimulus("s3_ok");     expectField("s3_store_pass", 16'h1FF0, 16'h1AA0);
    rx_store = 1'b0; rx_req = 1'b0;
    applyStimulus("s3_rxdrop");
    applyStimulus("s3_idle");

    // TX fetch from an empty buffer.
    tx_req = 1'b1; buffer_occupancy = 7'd0;
    applyStimulus("s4_idle");
    applyStimulus("s4_tx");
    tx_get = 1'b1;
    applyStimulus("s4_empty");  expectField("s4_get_blocked", M_GET, 16'h0000);
    tx_get = 1'b0;
    applyStimulus("s4_err");    expectField("s4_err_pulse", M_ERR, M_ERR);
    applyStimulus("s4_err_end"); expectField("s4_err_once", M_ERR, 16'h0000);
    tx_req = 1'b0;
    applyStimulus("s4_txdrop");
    applyStimulus("s4_idle2");

    // Host collisions: store beats get; clear beats store.
    host_req = 1'b1; buffer_occupancy = 7'd5;
    applyStimulus("h_idle");
    applyStimulus("h_grant");   expectField("h_gnt_host", M_GNT, 16'h2000);
    host_store = 1'b1; host_get = 1'b1; host_wdata = 8'h5A;
    applyStimulus("h_collide"); expectField("h_store_wins", 16'h1FF8, 16'h15A0);
    host_get = 1'b0; host_clear = 1'b1;
    applyStimulus("h_clear");   expectField("h_clear_wins", 16'h1FFC, 16'h0004);
    expectField("h_collide_err", M_ERR, M_ERR);
    host_store = 1'b0; host_clear = 1'b0;
    applyStimulus("h_quiet");   expectField("h_clear_no_err", M_ERR, 16'h0000);
    host_req = 1'b0;
    applyStimulus("h_drop");
    applyStimulus("h_idle2");

    // Silent host session times out and is regranted while host_req stays high.
    host_req = 1'b1;
    applyStimulus("s5_idle");
    for (int k = 0; k < 255; k++) begin
      applyStimulus("s5_hold");
      if (k == 254) expectField("s5_last_hold", M_GNT | M_TO, 16'h2000);
    end
    applyStimulus("s5_timeout"); expectField("s5_timeout", M_GNT | M_TO, 16'h0001);
    applyStimulus("s5_regrant"); expectField("s5_regrant", M_GNT | M_TO, 16'h2000);
    host_req = 1'b0;
    applyStimulus("s5_drop");
    applyStimulus("s5_idle2");

    // Reset in the middle of an RX packet with an erroring store pending.
    rx_req = 1'b1;
    applyStimulus("s6_idle");
    applyStimulus("s6_flush");
    applyStimulus("s6_rx");     expectField("s6_gnt_rx", M_GNT, 16'h8000);
    buffer_occupancy = 7'd64; rx_store = 1'b1; rst = 1'b1;
    applyStimulus("s6_rst");
    rst = 1'b0;
    applyStimulus("s6_after");  expectField("s6_all_zero", 16'hFFFF, 16'h0000);
    rx_req = 1'b0; rx_store = 1'b0;
    applyStimulus("s6_a");
    applyStimulus("s6_b");
    applyStimulus("s6_c");

    // Randomized traffic: requests held for a while, strobes and occupancy free-running.
    for (int i = 0; i < 1500; i++) begin
      int r;
      if ($urandom_range(0, 11) == 0) rx_req   = ~rx_req;
      if ($urandom_range(0, 11) == 0) tx_req   = ~tx_req;
      if ($urandom_range(0, 11) == 0) host_req = ~host_req;
      rx_store   = 1'($urandom_range(0, 1));
      tx_get     = 1'($urandom_range(0, 1));
      host_store = 1'($urandom_range(0, 1));
      host_get   = 1'($urandom_range(0, 1));
      host_clear = ($urandom_range(0, 7) == 0);
      rx_wdata   = 8'($urandom);
      host_wdata = 8'($urandom);
      r = $urandom_range(0, 3);
      if (r == 0)      buffer_occupancy = 7'd0;
      else if (r == 1) buffer_occupancy = 7'd64;
      else             buffer_occupancy = 7'($urandom_range(1, 63));
      rst = ($urandom_range(0, 149) == 0);
      applyStimulus("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
